byte_rr_arbiter: RTL

BYTE_RR_ARBITER -- requirements
Module: byte_rr_arbiter

---
 rtl/byte_rr_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/byte_rr_arbiter.sv
// Four-requester round-robin byte arbiter with a registered output stage.
// Optional burst mode (macro ARB_BURST_EN) lets a granted requester keep priority for BURST_LEN beats.
module byte_rr_arbiter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_0,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic [WIDTH-1:0] in_3,
  input  logic [3:0]       valid_in,
  output logic [3:0]       gnt,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             valid_out,
  output logic [1:0]       src_id
);

  if (BURST_LEN == 0) begin : g_bad_burst_len
    $error("BURST_LEN must be at least 1");
  end

  logic [1:0]       ptr_q, ptr_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic [1:0]       src_q, src_d;

  logic             sel_found;
  logic [1:0]       sel_idx;
  logic [1:0]       cand;
  logic [WIDTH-1:0] sel_data;
  logic             xfer;

  // First valid requester at or after ptr; depends only on inputs and ptr_q.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = ptr_q;
    cand      = ptr_q;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!sel_found && valid_in[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    gnt = 4'b0000;
    if (reset && out_ready && sel_found) begin
      gnt = 4'b0001 << sel_idx;
    end
  end

  assign xfer = |gnt;

  always_comb begin
    unique case (sel_idx)
      2'd0:    sel_data = in_0;
      2'd1:    sel_data = in_1;
      2'd2:    sel_data = in_2;
      default: sel_data = in_3;
    endcase
  end

  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    src_d   = src_q;
    if (out_ready) begin
      if (xfer) begin
        out_d   = sel_data;
        valid_d = 1'b1;
        src_d   = sel_idx;
      end else begin
        out_d   = '0;
        valid_d = 1'b0;
        src_d   = 2'd0;
      end
    end
  end

`ifdef ARB_BURST_EN
  localparam int unsigned CntW = $clog2(BURST_LEN + 1);

  logic [CntW-1:0] burst_q, burst_d;
  logic [CntW-1:0] cnt_inc;

  // A winner other than the pointer holder starts a fresh burst.
  always_comb begin
    ptr_d   = ptr_q;
    burst_d = burst_q;
    cnt_inc = burst_q;
    if (xfer) begin
      if (sel_idx == ptr_q) begin
        cnt_inc = burst_q + CntW'(1);
      end else begin
        cnt_inc = CntW'(1);
      end
      if (cnt_inc == CntW'(BURST_LEN)) begin
        ptr_d   = sel_idx + 2'd1;
        burst_d = '0;
      end else begin
        ptr_d   = sel_idx;
        burst_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      burst_q <= '0;
    end else begin
      burst_q <= burst_d;
    end
  end
`else
  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = sel_idx + 2'd1;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q   <= 2'd0;
      out_q   <= '0;
      valid_q <= 1'b0;
      src_q   <= 2'd0;
    end else begin
      ptr_q   <= ptr_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      src_q   <= src_d;
    end
  end

  assign out       = out_q;
  assign valid_out = valid_q;
  assign src_id    = src_q;

endmodule
